// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub. The master drives start/mode/A/B;
// the slave returns busy/done and the registered results.
interface serial_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             C;
  logic             Overflow;

  modport master (
    output start, mode, A, B,
    input  busy, done, Sum, C, Overflow
  );

  modport slave (
    input  start, mode, A, B,
    output busy, done, Sum, C, Overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Chunk-serial adder/subtractor: one CHUNK-bit slice per clock, LSB first.
// Optional saturation on signed overflow via `define SERIAL_ADDSUB_SATURATE_EN.
module serial_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);

  localparam int NSL = WIDTH / CHUNK;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_param
    $error("serial_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q, c_q, ovf_q;
  logic [CW-1:0]    cnt_q;

  logic [CHUNK-1:0] a_s, b_s, s_s;
  logic             cout_s, cmsb_s, last;

  // Slice datapath; carry into the slice MSB is recovered from its sum bit.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_s    = a_q[cnt_q*CHUNK +: CHUNK];
    b_s    = b_q[cnt_q*CHUNK +: CHUNK];
    {cout_s, s_s} = {1'b0, a_s} + {1'b0, b_s} + (CHUNK+1)'(carry_q);
    cmsb_s = a_s[CHUNK-1] ^ b_s[CHUNK-1] ^ s_s[CHUNK-1];
    last   = (cnt_q == LAST);

    sum_d = sum_q;
    sum_d[cnt_q*CHUNK +: CHUNK] = s_s;
`ifdef SERIAL_ADDSUB_SATURATE_EN
    // A wrapped-negative MSB on overflow means the true result was positive.
    if (last && (cout_s ^ cmsb_s)) begin
      sum_d = s_s[CHUNK-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                           : {1'b1, {(WIDTH-1){1'b0}}};
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_q     <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            carry_q <= bus.mode;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= cout_s;
          cnt_q   <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            c_q   <= cout_s;
            ovf_q <= cout_s ^ cmsb_s;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand registers are loaded before use on every start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) begin
      a_q <= bus.A;
      b_q <= bus.mode ? ~bus.B : bus.B;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.Sum      = sum_q;
  assign bus.C        = c_q;
  assign bus.Overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: a 16/4 instance and an 8/8 instance,
// expected results queued at start and compared on each done pulse.
module tb_serial_addsub;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done16 = 0;
  int   n_done8  = 0;
  exp_t q16[$];
  exp_t q8[$];

  always #5 clk = ~clk;

  serial_addsub_if #(.WIDTH(16)) bus16 ();
  serial_addsub_if #(.WIDTH(8))  bus8 ();

  serial_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  serial_addsub #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: full-width two's-complement arithmetic, independent of slicing.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic m);
    logic [16:0] mask, av, bv, full, res;
    exp_t e;
    mask  = (17'd1 << w) - 17'd1;
    av    = {1'b0, a} & mask;
    bv    = (m ? ~{1'b0, b} : {1'b0, b}) & mask;
    full  = av + bv + {16'd0, m};
    e.c   = full[w];
    res   = full & mask;
    e.ovf = (av[w-1] == bv[w-1]) && (res[w-1] != av[w-1]);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    if (e.ovf) res = res[w-1] ? (mask >> 1) : (17'd1 << (w-1));
`endif
    e.sum = res[15:0];
    return e;
  endfunction

  function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.c = c; e.ovf = o;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus16.done) begin
      n_done16++;
      if (q16.size() == 0) check("spurious_done16", 1, 0);
      else begin
        e = q16.pop_front();
        check("sum16", bus16.Sum, e.sum);
        check("c16", bus16.C, e.c);
        check("ovf16", bus16.Overflow, e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus8.done) begin
      n_done8++;
      if (q8.size() == 0) check("spurious_done8", 1, 0);
      else begin
        e = q8.pop_front();
        check("sum8", bus8.Sum, e.sum);
        check("c8", bus8.C, e.c);
        check("ovf8", bus8.Overflow, e.ovf);
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic m, input exp_t e);
    int lat, nb;
    q16.push_back(e);
    bus16.A = a; bus16.B = b; bus16.mode = m; bus16.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus16.start = 1'b0; bus16.A = ~a; bus16.B = ~b; bus16.mode = ~m;
    lat = 1; nb = bus16.busy ? 1 : 0;
    while (!bus16.done && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (bus16.busy) nb++;
    end
    check("latency16", lat, 5);
    check("busy_cycles16", nb, 5);
    @(posedge clk); @(negedge clk);
    check("idle_busy16", bus16.busy, 0);
    check("done_pulse16", bus16.done, 0);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic m, input exp_t e);
    int lat;
    q8.push_back(e);
    bus8.A = a; bus8.B = b; bus8.mode = m; bus8.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus8.start = 1'b0; bus8.A = ~a; bus8.B = ~b;
    lat = 1;
    while (!bus8.done && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("latency8", lat, 2);
    @(posedge clk); @(negedge clk);
    check("idle_busy8", bus8.busy, 0);
  endtask

  initial begin
    int d0, lat;
    logic [15:0] ra, rb;
    logic        rm;

    rst = 1'b1;
    bus16.start = 1'b1; bus16.mode = 1'b0; bus16.A = 16'h1234; bus16.B = 16'h1111;
    bus8.start  = 1'b0; bus8.mode  = 1'b0; bus8.A  = 8'h00;    bus8.B  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy16", bus16.busy, 0);
    check("rst_done16", bus16.done, 0);
    check("rst_sum16", bus16.Sum, 0);
    check("rst_c16", bus16.C, 0);
    check("rst_ovf16", bus16.Overflow, 0);
    check("rst_busy8", bus8.busy, 0);
    check("rst_sum8", bus8.Sum, 0);
    bus16.start = 1'b0;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    op16(16'd10, 16'd2, 1'b1, mk(16'h0008, 1'b1, 1'b0));
    repeat (3) @(negedge clk);
    check("hold_sum16", bus16.Sum, 16'h0008);
    check("hold_c16", bus16.C, 1);
    op16(16'h0002, 16'h000A, 1'b1, mk(16'hFFF8, 1'b0, 1'b0));
`ifdef SERIAL_ADDSUB_SATURATE_EN
    op16(16'h7FFF, 16'h0001, 1'b0, mk(16'h7FFF, 1'b0, 1'b1));
    op16(16'h8000, 16'h0001, 1'b1, mk(16'h8000, 1'b1, 1'b1));
`else
    op16(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
    op16(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
`endif
    op16(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
    op16(16'h1234, 16'h1234, 1'b1, mk(16'h0000, 1'b1, 1'b0));

    // Second start while busy, then another start in the DONE cycle: both ignored.
    d0 = n_done16;
    q16.push_back(mk(16'h0011, 1'b0, 1'b0));
    bus16.A = 16'd15; bus16.B = 16'd2; bus16.mode = 1'b0; bus16.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus16.A = 16'hFFFF; bus16.mode = 1'b1;
    @(posedge clk); @(negedge clk);
    bus16.start = 1'b0;
    lat = 0;
    while (!bus16.done && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("ignored_start_timeout", (lat < 20) ? 1 : 0, 1);
    bus16.start = 1'b1; bus16.A = 16'h0001; bus16.B = 16'h0001;
    @(posedge clk); @(negedge clk);
    check("done_cycle_start_ignored", bus16.busy, 0);
    bus16.start = 1'b0;
    repeat (6) @(negedge clk);
    check("single_done", n_done16 - d0, 1);

    // Abort on the third RUN cycle: no done, everything cleared.
    d0 = n_done16;
    bus16.A = 16'h4444; bus16.B = 16'h1111; bus16.mode = 1'b0; bus16.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus16.start = 1'b0;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus16.busy, 0);
    check("abort_done", bus16.done, 0);
    check("abort_sum", bus16.Sum, 0);
    check("abort_c", bus16.C, 0);
    check("abort_ovf", bus16.Overflow, 0);
    repeat (8) @(negedge clk);
    check("abort_no_done", n_done16 - d0, 0);
    op16(16'd3, 16'd4, 1'b0, mk(16'h0007, 1'b0, 1'b0));

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom_range(1, 0));
      op16(ra, rb, rm, model(16, ra, rb, rm));
    end

`ifdef SERIAL_ADDSUB_SATURATE_EN
    op8(8'h80, 8'h01, 1'b1, mk(16'h0080, 1'b1, 1'b1));
    op8(8'h7F, 8'h01, 1'b0, mk(16'h007F, 1'b0, 1'b1));
`else
    op8(8'h80, 8'h01, 1'b1, mk(16'h007F, 1'b1, 1'b1));
    op8(8'h7F, 8'h01, 1'b0, mk(16'h0080, 1'b0, 1'b1));
`endif
    op8(8'h05, 8'h09, 1'b1, mk(16'h00FC, 1'b0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom_range(255, 0));
      rb = 16'($urandom_range(255, 0));
      rm = 1'($urandom_range(1, 0));
      op8(ra[7:0], rb[7:0], rm, model(8, ra, rb, rm));
    end

    repeat (2) @(negedge clk);
    check("q16_drained", q16.size(), 0);
    check("q8_drained", q8.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 Parameter WIDTH SHALL be: default 16, meaning operand/result width in bits.
REQ-002 Parameter CHUNK SHALL be: default 4, meaning bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK; CHUNK=WIDTH is legal.
REQ-003 Port list SHALL be:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  operation request, sampled in IDLE only.
- mode  input  1  0 = add (A+B), 1 = subtract (A-B).
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when results are valid.
- Sum  output  WIDTH  result.
- C  output  1  final carry out; in subtract mode 1 = no borrow.
- Overflow  output  1  signed two's-complement overflow.
REQ-004 There SHALL be one clock; reset SHALL be synchronous and active-high.

Function
REQ-005 The FSM SHALL have states IDLE, RUN and DONE.
REQ-006 IDLE to RUN SHALL occur on a clock edge with start=1; on that edge A, B and mode SHALL be latched.
REQ-007 Latching SHALL store B inverted when mode=1, and SHALL preset the internal carry to mode (two's-complement subtract: A + ~B + 1).
REQ-008 In RUN, each cycle SHALL add one CHUNK-bit slice, LSB slice first, using the stored carry, writing that slice of Sum and updating the carry.
REQ-009 A slice counter SHALL count 0..WIDTH/CHUNK-1; after the last slice the FSM SHALL go to DONE.
REQ-010 Latency SHALL be WIDTH/CHUNK+1 cycles from the start edge to done high (16/4: done high on the 5th edge after start).
REQ-011 In DONE, for exactly one cycle: done=1, C = final carry, Overflow = carry into MSB XOR carry out of MSB; the next state SHALL be IDLE.
REQ-012 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-013 start SHALL be ignored while busy=1; a start asserted in the DONE cycle SHALL NOT be accepted.
REQ-014 Changes on A, B or mode after the start edge SHALL NOT affect the result.
REQ-015 Sum, C and Overflow SHALL hold their values from the done cycle until the next accepted start.
REQ-016 Sum SHALL NOT be read before done; intermediate slice values are undefined to the user.
REQ-017 Back-to-back operation SHALL be possible: start in the IDLE cycle directly after DONE is accepted.

Reset
REQ-018 rst=1 SHALL force IDLE, with busy=0, done=0, Sum=0, C=0, Overflow=0, slice counter=0 and internal carry=0.
REQ-019 rst during RUN or DONE SHALL abort the operation with no done pulse; rst SHALL take priority over start on the same edge.

Configuration
REQ-020 Macro SERIAL_ADDSUB_SATURATE_EN SHALL control saturation.
- Defined: when Overflow=1 in DONE, Sum SHALL be replaced by 0111...1 if the true result is positive, or 1000...0 if negative; Overflow SHALL still report 1, and C SHALL be unchanged.
- Undefined: Sum SHALL be the wrapped modulo-2^WIDTH result.
- Latency SHALL be identical in both builds.

Verification (WIDTH=16, CHUNK=4 unless noted)
REQ-021 A=10, B=2, mode=1, start pulse -> done on the 5th edge after start; Sum=0x0008, C=1, Overflow=0; busy high for 5 cycles.
REQ-022 A=0x0002, B=0x000A, mode=1 -> Sum=0xFFF8, C=0, Overflow=0.
REQ-023 A=0x7FFF, B=0x0001, mode=0 -> Overflow=1, C=0; Sum=0x8000 with macro undefined, Sum=0x7FFF with SERIAL_ADDSUB_SATURATE_EN defined.
REQ-024 Start A=15, B=2, mode=0, then on the 2nd cycle assert start with A=0xFFFF and change A -> single done; Sum=0x0011; second start ignored.
REQ-025 Start an operation, assert rst on the 3rd RUN cycle -> no done pulse; all outputs 0 and busy=0 on the next cycle; a following start (A=3, B=4, mode=0) -> Sum=0x0007.
REQ-026 WIDTH=8, CHUNK=8, A=0x80, B=0x01, mode=1 -> done on the 2nd edge after start; Sum=0x7F, C=1, Overflow=1 (0x80 with saturation).
